// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: write-back port arbiter and pending-write scoreboard
// for the 32-entry register file.
// Build option: define WB_RR_ARB_EN for round-robin arbitration between the
// ALU (A) and load (B) requesters; otherwise B has fixed priority over A.
module regfile_wb_scheduler #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [AW-1:0]    a_rd,
    input  logic [XLEN-1:0]  a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [AW-1:0]    b_rd,
    input  logic [XLEN-1:0]  b_data,
    output logic             b_ready,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_rd,
    output logic             rsv_ready,
    output logic             reg_write,
    output logic [AW-1:0]    write_reg,
    output logic [XLEN-1:0]  write_data,
    output logic [NREG-1:0]  busy_mask,
    output logic [CNT_W-1:0] commit_cnt
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    logic             r_reg_write;
    logic [AW-1:0]    r_write_reg;
    logic [XLEN-1:0]  r_write_data;
    logic [NREG-1:0]  r_busy;
    logic [CNT_W-1:0] r_commit_cnt;

    grant_e           w_grant;
    logic             w_xfer;
    logic [AW-1:0]    w_rd;
    logic [XLEN-1:0]  w_data;
    logic             w_commit;
    logic             w_rsv_set;
    logic [NREG-1:0]  w_busy_nxt;

`ifdef WB_RR_ARB_EN
    grant_e           r_last_grant;

    // Remember which requester won the most recent transfer (x0 included).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GRANT_A;
        end else if (w_xfer) begin
            r_last_grant <= w_grant;
        end
    end

    // Arbitration: on contention, grant the requester that did not win last.
    always_comb begin
        w_grant = GRANT_A;
        if (a_valid && b_valid) begin
            w_grant = (r_last_grant == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (b_valid) begin
            w_grant = GRANT_B;
        end
    end
`else
    // Arbitration: fixed priority, load unit (B) wins over ALU (A).
    always_comb begin
        w_grant = GRANT_A;
        if (b_valid) begin
            w_grant = GRANT_B;
        end
    end
`endif

    assign a_ready  = a_valid && (w_grant == GRANT_A);
    assign b_ready  = b_valid && (w_grant == GRANT_B);
    assign w_xfer   = (a_valid && a_ready) || (b_valid && b_ready);
    assign w_rd     = (w_grant == GRANT_B) ? b_rd   : a_rd;
    assign w_data   = (w_grant == GRANT_B) ? b_data : a_data;
    // Writes to x0 are accepted but dropped: no reg_write, no scoreboard or count change.
    assign w_commit = w_xfer && (w_rd != '0);

    assign rsv_ready = (rsv_rd == '0) || !r_busy[rsv_rd];
    assign w_rsv_set = rsv_valid && rsv_ready && (rsv_rd != '0);

    // Scoreboard next state: commit clears, reservation sets, set wins on a tie.
    always_comb begin
        w_busy_nxt    = r_busy;
        w_busy_nxt[0] = 1'b0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (w_commit && (w_rd == AW'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (w_rsv_set && (rsv_rd == AW'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
    end

    // Register-file write port: one-cycle registered image of the committed transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_reg_write <= w_commit;
            if (w_commit) begin
                r_write_reg  <= w_rd;
                r_write_data <= w_data;
            end
        end
    end

    // Pending-write flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Committed non-x0 write counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_commit_cnt <= '0;
        end else if (w_commit) begin
            r_commit_cnt <= r_commit_cnt + 1'b1;
        end
    end

    assign reg_write  = r_reg_write;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;
    assign busy_mask  = r_busy;
    assign commit_cnt = r_commit_cnt;

endmodule
